// File: rtl/iter_lzc_if.sv
// Handshake bundle for the iterative leading/trailing zero/one counter.
// Ports: request (in_valid/in_ready/in_data/in_mode), result (out_valid/out_ready/out_count/out_none).
interface iter_lzc_if #(
    parameter int WIDTH = 32
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_none;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_none
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_none
    );
endinterface

// File: rtl/iter_lzc.sv
// Iterative leading/trailing zero/one counter, scanning CHUNK bits per cycle.
// Ports: clk, rst (async, active high), bus (iter_lzc_if.slave), busy (state != IDLE).
module iter_lzc #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic       clk,
    input  logic       rst,
    iter_lzc_if.slave  bus,
    output logic       busy
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sr;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    count;
    logic             none;

    logic [CHUNK-1:0] top;
    logic [CW-1:0]    clz;
    logic             zero;
    logic             last;

    // Every mode is folded into a leading-zero count: reverse for the
    // trailing modes, invert for the counting-ones modes.
    function automatic logic [WIDTH-1:0] xform(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (m[1]) begin
            for (int i = 0; i < WIDTH; i++) begin
                r[i] = d[WIDTH-1-i];
            end
        end
        if (m[0]) begin
            r = ~r;
        end
        return r;
    endfunction

    // Leading zeros inside the current top chunk; highest set bit wins
    // because it is visited last.
    always_comb begin
        top = sr[WIDTH-1 -: CHUNK];
        clz = CW'(CHUNK);
        for (int i = 0; i < CHUNK; i++) begin
            if (top[i]) begin
                clz = CW'(CHUNK - 1 - i);
            end
        end
        zero = (top == '0);
        last = (idx == IW'(NCH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            idx   <= '0;
            count <= '0;
            none  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr    <= xform(bus.in_data, bus.in_mode);
                        count <= '0;
                        idx   <= '0;
                        none  <= 1'b0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (zero && !last) begin
                        count <= count + CW'(CHUNK);
                        sr    <= sr << CHUNK;
                        idx   <= idx + IW'(1);
                    end else if (zero) begin
                        count <= CW'(WIDTH);
                        none  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count <= count + clz;
                        none  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.out_count = count;
    assign bus.out_none  = none;
    assign busy          = (state != IDLE);
endmodule
